// File: rtl/parking_button_conditioner.sv
// Six-button input stage: sync, debounce, one pulse per accepted press, serialised by fixed priority.
// Optional auto-repeat on add1..add4 when AUTO_REPEAT_EN is defined.

module pbc_debounce #(
`ifdef AUTO_REPEAT_EN
  parameter bit REP_EN        = 1'b0,
  parameter int REPEAT_CYCLES = 2,
`endif
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic set_pend
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]    sync_q, sync_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d   = {sync_q[0], btn};
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) stable_d = sync_q[1];
      else                                   cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  logic [RW-1:0] rep_q, rep_d;
  logic          rep_hit;

  // Counter runs only while held; both the rise and the release leave it at zero.
  always_comb begin
    rep_d   = '0;
    rep_hit = 1'b0;
    if (REP_EN && stable_q && stable_d) begin
      if (rep_q == RW'(REPEAT_CYCLES - 1)) rep_hit = 1'b1;
      else                                 rep_d   = rep_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rep_q <= '0;
    else     rep_q <= rep_d;
  end

  assign set_pend = (~stable_q & stable_d) | rep_hit;
`else
  assign set_pend = ~stable_q & stable_d;
`endif
endmodule

module parking_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_add1,
  input  logic btn_add2,
  input  logic btn_add3,
  input  logic btn_add4,
  input  logic btn_rst1,
  input  logic btn_rst2,
  output logic add1,
  output logic add2,
  output logic add3,
  output logic add4,
  output logic rst1,
  output logic rst2,
  output logic pending_any
);
  localparam int NUM_BTN = 6;

  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
    $error("parking_button_conditioner: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
  end

  // Bit 0 is the highest priority (add1), bit 5 the lowest (rst2).
  logic [NUM_BTN-1:0] btn_raw, set_pend;
  logic [NUM_BTN-1:0] pend_q, pend_d, grant;
  logic [NUM_BTN-1:0] out_q, out_d;
  logic               pany_q, pany_d;

  assign btn_raw = {btn_rst2, btn_rst1, btn_add4, btn_add3, btn_add2, btn_add1};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    pbc_debounce #(
`ifdef AUTO_REPEAT_EN
      .REP_EN          (i < 4),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
`endif
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db (
      .clk      (clk),
      .rst      (rst),
      .btn      (btn_raw[i]),
      .set_pend (set_pend[i])
    );
  end

  // New sets are OR-ed in after the grant is removed, so a same-edge set survives the drain.
  always_comb begin
    grant  = pend_q & (~pend_q + 1'b1);
    pend_d = (pend_q & ~grant) | set_pend;
    out_d  = grant;
    pany_d = |pend_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      out_q  <= '0;
      pany_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      out_q  <= out_d;
      pany_q <= pany_d;
    end
  end

  assign {rst2, rst1, add4, add3, add2, add1} = out_q;
  assign pending_any = pany_q;
endmodule

// File: tb/tb_parking_button_conditioner.sv
// Directed bench for parking_button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
module tb_parking_button_conditioner;
  logic clk = 1'b0, rst = 1'b1;
  logic btn_add1 = 0, btn_add2 = 0, btn_add3 = 0, btn_add4 = 0, btn_rst1 = 0, btn_rst2 = 0;
  logic add1, add2, add3, add4, rst1, rst2, pending_any;
  int n_tests = 0, n_fail = 0;

  localparam logic [6:0] Z = 7'h00, A1 = 7'h01, A2 = 7'h02, A3 = 7'h04, A4 = 7'h08,
                         R1 = 7'h10, R2 = 7'h20, P = 7'h40;

  parking_button_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .btn_add1(btn_add1), .btn_add2(btn_add2), .btn_add3(btn_add3), .btn_add4(btn_add4),
    .btn_rst1(btn_rst1), .btn_rst2(btn_rst2),
    .add1(add1), .add2(add2), .add3(add3), .add4(add4), .rst1(rst1), .rst2(rst2),
    .pending_any(pending_any)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int e, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {pending_any, rst2, rst1, add4, add3, add2, add1};
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s edge %0d: got %b want %b", tag, e, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic [6:0] exp;
    // reset state
    idle(3);
    chk("reset_state", -1, Z);
    rst = 1'b0;
    idle(2);

    // 1: async reset while add2 pulses; queued work discarded
    btn_add2 = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      step();
      exp = (e == 5) ? P : (e == 6) ? A2 : Z;
      chk("t1_press", e, exp);
    end
    #2 rst = 1'b1;
    #1 chk("t1_async_rst", 6, Z);
    btn_add2 = 1'b0;
    idle(2);
    rst = 1'b0;
    for (int e = 0; e < 20; e++) begin step(); chk("t1_after_rst", e, Z); end
    idle(4);

    // 2: add2 held 10 cycles
    btn_add2 = 1'b1;
    for (int e = 0; e < 30; e++) begin
      step();
      exp = (e == 5) ? P : (e == 6) ? A2 : Z;
      chk("t2_add2", e, exp);
      if (e == 9) btn_add2 = 1'b0;
    end
    idle(12);

    // 3: short add1 press is ignored
    btn_add1 = 1'b1;
    for (int e = 0; e < 25; e++) begin
      step();
      chk("t3_short", e, Z);
      if (e == 2) btn_add1 = 1'b0;
    end
    idle(12);

    // 4: add3 and rst1 together, add3 wins
    btn_add3 = 1'b1; btn_rst1 = 1'b1;
    for (int e = 0; e < 30; e++) begin
      step();
      exp = (e == 5) ? P : (e == 6) ? (A3 | P) : (e == 7) ? R1 : Z;
      chk("t4_prio", e, exp);
      if (e == 19) begin btn_add3 = 1'b0; btn_rst1 = 1'b0; end
    end
    idle(12);

    // 5: add4 bounces for 12 cycles then held from edge 12
    btn_add4 = 1'b1;
    for (int e = 0; e < 40; e++) begin
      step();
      exp = (e == 17) ? P : (e == 18) ? A4 : Z;
      chk("t5_bounce", e, exp);
      if (e + 1 < 12)      btn_add4 = (((e + 1) / 2) % 2) == 0;
      else if (e + 1 < 30) btn_add4 = 1'b1;
      else                 btn_add4 = 1'b0;
    end
    idle(12);

    // 6a: add1 held 30 cycles
    btn_add1 = 1'b1;
    for (int e = 0; e < 45; e++) begin
      step();
`ifdef AUTO_REPEAT_EN
      exp = (e == 5 || e == 13 || e == 21 || e == 29) ? P :
            (e == 6 || e == 14 || e == 22 || e == 30) ? A1 : Z;
`else
      exp = (e == 5) ? P : (e == 6) ? A1 : Z;
`endif
      chk("t6_add1_hold", e, exp);
      if (e == 29) btn_add1 = 1'b0;
    end
    idle(12);

    // 6b: rst2 held 30 cycles never repeats
    btn_rst2 = 1'b1;
    for (int e = 0; e < 45; e++) begin
      step();
      exp = (e == 5) ? P : (e == 6) ? R2 : Z;
      chk("t6_rst2_hold", e, exp);
      if (e == 29) btn_rst2 = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
